// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: multi-cycle radix-2 restoring divide sequencer for EX.
// Holds the pipeline via stall_req while dividing; result is {HI=rem, LO=quo}.
// Configuration macro: DIV_SIGNED_EN -- when defined, signed_div selects DIV
// (operand pre-negation and result sign fix); when undefined every request is
// treated as DIVU and no negation logic is built.
module div_seq_ctrl #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              signed_div,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    input  logic              annul,
    output logic              stall_req,
    output logic              ready,
    output logic [DATA_W-1:0] result_hi,
    output logic [DATA_W-1:0] result_lo
);

    typedef enum logic [1:0] {S_IDLE, S_BY_ZERO, S_ON, S_END} state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rem_q, quo_q, dvs_q;
    logic [DATA_W-1:0] a_abs, b_abs;
    logic [DATA_W:0]   rem_sh;
    logic              no_borrow;
    logic [DATA_W-1:0] rem_nx, quo_nx;
    logic [DATA_W-1:0] fix_q, fix_r;
    logic              go, last;

    assign go   = start && !annul;
    assign last = (cnt == CNT_W'(DATA_W - 1));

`ifdef DIV_SIGNED_EN
    logic a_neg, b_neg;
    logic neg_quo_q, neg_rem_q;

    // Magnitudes of the operands for a signed request
    always_comb begin
        a_neg = signed_div && dividend[DATA_W-1];
        b_neg = signed_div && divisor[DATA_W-1];
        a_abs = a_neg ? (DATA_W'(0) - dividend) : dividend;
        b_abs = b_neg ? (DATA_W'(0) - divisor)  : divisor;
    end

    // Quotient negative on sign mismatch; remainder follows the dividend
    always_comb begin
        fix_q = neg_quo_q ? (DATA_W'(0) - quo_nx) : quo_nx;
        fix_r = neg_rem_q ? (DATA_W'(0) - rem_nx) : rem_nx;
    end

    // Sign flags captured together with the operands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (state == S_IDLE && go && divisor != '0) begin
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
        end
    end
`else
    logic unused_signed_div;
    assign unused_signed_div = signed_div;

    // Unsigned-only build: operands and results pass straight through
    always_comb begin
        a_abs = dividend;
        b_abs = divisor;
        fix_q = quo_nx;
        fix_r = rem_nx;
    end
`endif

    // One restoring step: shift {rem,quo}, trial-subtract, set quotient bit.
    // The partial remainder stays below the divisor, so the DATA_W-bit
    // difference is exact whenever it is kept.
    always_comb begin
        rem_sh    = {rem_q, quo_q[DATA_W-1]};
        no_borrow = (rem_sh >= {1'b0, dvs_q});
        rem_nx    = no_borrow ? (rem_sh[DATA_W-1:0] - dvs_q) : rem_sh[DATA_W-1:0];
        quo_nx    = {quo_q[DATA_W-2:0], no_borrow};
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state logic; annul wins over completing the final step
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (go) state_nx = (divisor == '0) ? S_BY_ZERO : S_ON;
            S_ON:      if (annul) state_nx = S_IDLE;
                       else if (last) state_nx = S_END;
            S_BY_ZERO: state_nx = annul ? S_IDLE : S_END;
            S_END:     if (!start) state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    // Outputs decoded from state; the request cycle in IDLE already stalls
    always_comb begin
        stall_req = 1'b0;
        ready     = 1'b0;
        case (state)
            S_IDLE:    stall_req = go;
            S_ON:      stall_req = 1'b1;
            S_BY_ZERO: stall_req = 1'b1;
            S_END:     ready     = 1'b1;
            default:   stall_req = 1'b0;
        endcase
    end

    // Datapath: operand latch, iteration, result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            result_hi <= '0;
            result_lo <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (go && divisor != '0) begin
                        cnt   <= '0;
                        rem_q <= '0;
                        quo_q <= a_abs;
                        dvs_q <= b_abs;
                    end
                end
                S_ON: begin
                    if (!annul) begin
                        rem_q <= rem_nx;
                        quo_q <= quo_nx;
                        cnt   <= cnt + CNT_W'(1);
                        if (last) begin
                            result_hi <= fix_r;
                            result_lo <= fix_q;
                        end
                    end
                end
                S_BY_ZERO: begin
                    if (!annul) begin
                        result_hi <= '0;
                        result_lo <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
